// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK bit scheduler.
package qpsk_pkg;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/iq_phase_tff.sv
// Toggle flip-flop tracking the I/Q phase of the incoming bit stream.
module iq_phase_tff (
    input  logic clk,
    input  logic enable,
    input  logic clear,
    output logic q
);

    logic q_reg;

    // clear is active-low and synchronous; it dominates a toggle
    always_ff @(posedge clk) begin
        if (!clear) begin
            q_reg <= 1'b0;
        end else if (enable) begin
            q_reg <= ~q_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/qpsk_bit_scheduler.sv
// Pairs a serial bit stream into {I,Q} QPSK symbols behind a valid/ready output.
module qpsk_bit_scheduler
    import qpsk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             flush,
    output logic             i_bit,
    output logic             q_bit,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             sym_pad,
    output logic             phase,
    output logic [CNT_W-1:0] sym_count
);

    state_t           state;
    logic             phase_q;
    logic             accept;
    logic             take;
    logic             flush_emit;

    logic             held_i_reg,    held_i_next;
    logic             i_bit_reg,     i_bit_next;
    logic             q_bit_reg,     q_bit_next;
    logic             sym_valid_reg, sym_valid_next;
    logic             sym_pad_reg,   sym_pad_next;
    logic [CNT_W-1:0] count_reg,     count_next;

    iq_phase_tff u_phase (
        .clk    (clk),
        .enable (accept),
        .clear  (reset && !flush_emit),
        .q      (phase_q)
    );

    assign state = state_t'(phase_q);

    always_comb begin
        bit_ready      = 1'b0;
        accept         = 1'b0;
        take           = 1'b0;
        flush_emit     = 1'b0;
        held_i_next    = held_i_reg;
        i_bit_next     = i_bit_reg;
        q_bit_next     = q_bit_reg;
        sym_valid_next = sym_valid_reg;
        sym_pad_next   = sym_pad_reg;
        count_next     = count_reg;

        // A Q bit may only enter when the output slot is free or being drained
        bit_ready  = reset && en && !(state == ODD && sym_valid_reg && !sym_ready);
        accept     = bit_valid && bit_ready;
        take       = sym_valid_reg && sym_ready;
        flush_emit = flush && (state == ODD) && !accept && (!sym_valid_reg || sym_ready);

        if (take) begin
            sym_valid_next = 1'b0;
            count_next     = count_reg + CNT_W'(1);
        end

        if (accept && state == EVEN) begin
            held_i_next = bit_in;
        end else if (accept && state == ODD) begin
            i_bit_next     = held_i_reg;
            q_bit_next     = bit_in;
            sym_pad_next   = 1'b0;
            sym_valid_next = 1'b1;
        end else if (flush_emit) begin
            i_bit_next     = held_i_reg;
            q_bit_next     = 1'b0;
            sym_pad_next   = 1'b1;
            sym_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            held_i_reg    <= 1'b0;
            i_bit_reg     <= 1'b0;
            q_bit_reg     <= 1'b0;
            sym_valid_reg <= 1'b0;
            sym_pad_reg   <= 1'b0;
            count_reg     <= '0;
        end else begin
            held_i_reg    <= held_i_next;
            i_bit_reg     <= i_bit_next;
            q_bit_reg     <= q_bit_next;
            sym_valid_reg <= sym_valid_next;
            sym_pad_reg   <= sym_pad_next;
            count_reg     <= count_next;
        end
    end

    assign i_bit     = i_bit_reg;
    assign q_bit     = q_bit_reg;
    assign sym_valid = sym_valid_reg;
    assign sym_pad   = sym_pad_reg;
    assign phase     = phase_q;
    assign sym_count = count_reg;

endmodule

// File: tb/tb_qpsk_bit_scheduler.sv
// Randomized and directed bench for qpsk_bit_scheduler against a bit-pairing reference model.
module tb_qpsk_bit_scheduler;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, en, bit_in, bit_valid, flush, sym_ready;
    logic          bit_ready, i_bit, q_bit, sym_valid, sym_pad, phase;
    logic [CW-1:0] sym_count;

    int checks = 0;
    int errors = 0;

    // reference model: a pending-I slot plus one presented symbol
    bit     m_have_i;
    bit     m_i;
    bit     m_valid, m_si, m_sq, m_pad;
    int     m_count;

    always #5 clk = ~clk;

    qpsk_bit_scheduler #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .flush     (flush),
        .i_bit     (i_bit),
        .q_bit     (q_bit),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_pad   (sym_pad),
        .phase     (phase),
        .sym_count (sym_count)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // one clock cycle: drive, check ready, advance model, check outputs
    task automatic step(input bit r, input bit e, input bit bv, input bit b,
                        input bit fl, input bit sr);
        bit exp_ready, acc, tk, femit;
        @(negedge clk);
        reset = r; en = e; bit_valid = bv; bit_in = b; flush = fl; sym_ready = sr;
        #1;
        exp_ready = r && e && !(m_have_i && m_valid && !sr);
        check_val("bit_ready", int'(bit_ready), int'(exp_ready));
        acc   = bv && exp_ready;
        tk    = m_valid && sr;
        femit = fl && m_have_i && !acc && (!m_valid || sr);
        if (!r) begin
            m_have_i = 0; m_i = 0; m_valid = 0; m_si = 0; m_sq = 0; m_pad = 0; m_count = 0;
        end else begin
            if (tk) begin
                m_valid = 0;
                m_count = (m_count + 1) % (1 << CW);
            end
            if (acc && !m_have_i) begin
                m_i = b; m_have_i = 1;
            end else if (acc && m_have_i) begin
                m_si = m_i; m_sq = b; m_pad = 0; m_valid = 1; m_have_i = 0;
            end else if (femit) begin
                m_si = m_i; m_sq = 0; m_pad = 1; m_valid = 1; m_have_i = 0;
            end
        end
        @(posedge clk);
        #1;
        check_val("sym_valid", int'(sym_valid), int'(m_valid));
        check_val("i_bit",     int'(i_bit),     int'(m_si));
        check_val("q_bit",     int'(q_bit),     int'(m_sq));
        check_val("sym_pad",   int'(sym_pad),   int'(m_pad));
        check_val("phase",     int'(phase),     int'(m_have_i));
        check_val("sym_count", int'(sym_count), m_count);
        $display("cyc r=%0b en=%0b bv=%0b b=%0b fl=%0b sr=%0b -> v=%0b iq=%0b%0b pad=%0b ph=%0b cnt=%0d",
                 r, e, bv, b, fl, sr, sym_valid, i_bit, q_bit, sym_pad, phase, sym_count);
    endtask

    initial begin
        reset = 0; en = 0; bit_in = 0; bit_valid = 0; flush = 0; sym_ready = 0;
        m_have_i = 0; m_i = 0; m_valid = 0; m_si = 0; m_sq = 0; m_pad = 0; m_count = 0;

        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        check_val("rst_count", int'(sym_count), 0);

        // stream 1,0,1,1 with downstream always ready
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 1, 0, 0, 1);
        check_val("s1_iq", int'({i_bit, q_bit}), 2);
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 0, 1);
        check_val("s2_iq", int'({i_bit, q_bit}), 3);
        step(1, 1, 0, 0, 0, 1);
        check_val("cnt_two", int'(sym_count), 2);

        // stall: {1,0} presented, then I=0 accepted, Q=1 blocked until ready
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        check_val("stall_iq", int'({i_bit, q_bit}), 2);
        step(1, 1, 1, 1, 0, 1);
        check_val("nobubble_iq", int'({i_bit, q_bit}), 1);
        check_val("nobubble_v", int'(sym_valid), 1);
        step(1, 1, 0, 0, 0, 1);

        // single bit then flush; then flush in EVEN
        step(1, 1, 1, 1, 0, 1);
        step(1, 1, 0, 0, 1, 1);
        check_val("flush_pad", int'(sym_pad), 1);
        check_val("flush_iq", int'({i_bit, q_bit}), 2);
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1, 1);
        check_val("flush_even", int'(sym_valid), 0);

        // reset while ODD with a stalled symbol
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        check_val("rst_mid_v", int'(sym_valid), 0);
        step(0, 1, 1, 0, 1, 1);

        // en low mid-symbol
        step(1, 1, 1, 1, 0, 1);
        for (int k = 0; k < 5; k++) step(1, 0, 1, 0, 0, 1);
        check_val("en_hold_ph", int'(phase), 1);
        step(1, 1, 1, 0, 0, 1);
        check_val("en_done_v", int'(sym_valid), 1);

        // 17 symbols from zero wraps a 4-bit counter to 1
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            step(1, 1, 1, k[0], 0, 1);
            step(1, 1, 1, k[1], 0, 1);
        end
        step(1, 1, 0, 0, 0, 1);
        check_val("wrap_cnt", int'(sym_count), 1);

        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
